// File: rtl/maxpool_pkg.sv
// Shared types, window read-order offsets and the signed max helper for the max-pool engine.
package maxpool_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WR   = 2'd2,
    DONE = 2'd3
  } state_t;

  // Bit k holds the row / column offset of the k-th read inside a 2x2 window:
  // (0,0), (1,0), (0,1), (1,1).
  localparam logic [3:0] WIN_DR = 4'b1010;
  localparam logic [3:0] WIN_DC = 4'b1100;

  localparam int MAX_BW = 64;

  // Address width for n locations, never below one bit.
  function automatic int aw_of(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Signed max; on a tie the first operand (the earlier element) wins.
  function automatic logic signed [MAX_BW-1:0] max2(input logic signed [MAX_BW-1:0] a,
                                                    input logic signed [MAX_BW-1:0] b);
    return (b > a) ? b : a;
  endfunction

endpackage

// File: rtl/maxpool_seq_ctrl_if.sv
// Start/done handshake plus input-buffer read port and output-buffer write port of the max-pool engine.
interface maxpool_seq_ctrl_if #(
  parameter int BITWIDTH = 32,
  parameter int RD_AW    = 8,
  parameter int WR_AW    = 6
);
  logic                start;
  logic                busy;
  logic                done;
  logic                rd_en;
  logic [RD_AW-1:0]    rd_addr;
  logic [BITWIDTH-1:0] rd_data;
  logic                wr_en;
  logic [WR_AW-1:0]    wr_addr;
  logic [BITWIDTH-1:0] wr_data;

  modport master (
    output start, rd_data,
    input  busy, done, rd_en, rd_addr, wr_en, wr_addr, wr_data
  );

  modport slave (
    input  start, rd_data,
    output busy, done, rd_en, rd_addr, wr_en, wr_addr, wr_data
  );
endinterface

// File: rtl/maxpool_cmp.sv
// Registered signed compare/accumulate unit: load seeds the window, cmp_en folds in the next element,
// result is the combinational max of the accumulator and the incoming element.
module maxpool_cmp
  import maxpool_pkg::*;
#(
  parameter int BITWIDTH = 32
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       load,
  input  logic                       cmp_en,
  input  logic signed [BITWIDTH-1:0] din,
  output logic signed [BITWIDTH-1:0] result
);
  logic signed [BITWIDTH-1:0] acc;
  logic signed [BITWIDTH-1:0] mx;

  assign mx     = BITWIDTH'(max2(MAX_BW'(acc), MAX_BW'(din)));
  assign result = mx;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc <= '0;
    end else if (load) begin
      acc <= din;
    end else if (cmp_en) begin
      acc <= mx;
    end
  end
endmodule

// File: rtl/maxpool_seq_ctrl.sv
// 2x2/stride-2 max-pool sequencer: reads each window in four cycles and writes one pooled word in the fifth.
// Build option MAXPOOL_RELU_EN clamps negative pooled results to zero.
// state | meaning
// IDLE  | waiting for start
// RD    | window reads, sub-counter k = 0..3
// WR    | write of the pooled window value
// DONE  | one-cycle completion pulse
module maxpool_seq_ctrl
  import maxpool_pkg::*;
#(
  parameter int BITWIDTH = 32,
  parameter int CHANNELS = 2,
  parameter int IN_DIM   = 10
) (
  input logic               clk,
  input logic               rst_n,
  maxpool_seq_ctrl_if.slave bus
);
  localparam int OUT_DIM = IN_DIM / 2;
  localparam int RD_AW   = aw_of(CHANNELS * IN_DIM * IN_DIM);
  localparam int WR_AW   = aw_of(CHANNELS * OUT_DIM * OUT_DIM);
  localparam int CW      = aw_of(CHANNELS);
  localparam int OW      = aw_of(OUT_DIM);

  state_t                     state, state_d;
  logic [CW-1:0]              c, c_d;
  logic [OW-1:0]              i, i_d, j, j_d;
  logic [1:0]                 k, k_d;
  logic                       last_win;
  logic                       busy_q, done_q, rd_en_q, wr_en_q;
  logic [RD_AW-1:0]           rd_addr_q, rd_addr_d;
  logic [WR_AW-1:0]           wr_addr_q, wr_addr_d;
  logic                       cap_load, cap_cmp;
  logic signed [BITWIDTH-1:0] pool_max, pool_out;

  assign last_win = (c == CW'(CHANNELS - 1)) && (i == OW'(OUT_DIM - 1)) && (j == OW'(OUT_DIM - 1));

  always_comb begin
    state_d = state;
    c_d     = c;
    i_d     = i;
    j_d     = j;
    k_d     = k;
    case (state)
      IDLE: begin
        if (bus.start) begin
          state_d = RD;
          c_d     = '0;
          i_d     = '0;
          j_d     = '0;
          k_d     = '0;
        end
      end
      RD: begin
        k_d = k + 2'd1;
        if (k == 2'd3) state_d = WR;
      end
      WR: begin
        if (last_win) begin
          state_d = DONE;
        end else begin
          state_d = RD;
          if (j == OW'(OUT_DIM - 1)) begin
            j_d = '0;
            if (i == OW'(OUT_DIM - 1)) begin
              i_d = '0;
              c_d = c + CW'(1);
            end else begin
              i_d = i + OW'(1);
            end
          end else begin
            j_d = j + OW'(1);
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Addresses are formed from the next-cycle counters so the strobes and addresses leave on flops.
  always_comb begin
    rd_addr_d = '0;
    wr_addr_d = '0;
    if (state_d == RD) begin
      rd_addr_d = RD_AW'((int'(c_d) * IN_DIM + 2 * int'(i_d) + int'(WIN_DR[k_d])) * IN_DIM
                         + 2 * int'(j_d) + int'(WIN_DC[k_d]));
    end
    if (state_d == WR) begin
      wr_addr_d = WR_AW'((int'(c_d) * OUT_DIM + int'(i_d)) * OUT_DIM + int'(j_d));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      c         <= '0;
      i         <= '0;
      j         <= '0;
      k         <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      rd_en_q   <= 1'b0;
      wr_en_q   <= 1'b0;
      rd_addr_q <= '0;
      wr_addr_q <= '0;
    end else begin
      state     <= state_d;
      c         <= c_d;
      i         <= i_d;
      j         <= j_d;
      k         <= k_d;
      busy_q    <= (state_d == RD) || (state_d == WR);
      done_q    <= (state_d == DONE);
      rd_en_q   <= (state_d == RD);
      wr_en_q   <= (state_d == WR);
      rd_addr_q <= rd_addr_d;
      wr_addr_q <= wr_addr_d;
    end
  end

  // Read data trails rd_en by one cycle: k=1 carries element 0, k=2/3 elements 1/2, WR element 3.
  assign cap_load = (state == RD) && (k == 2'd1);
  assign cap_cmp  = (state == RD) && k[1];

  maxpool_cmp #(
    .BITWIDTH(BITWIDTH)
  ) u_cmp (
    .clk    (clk),
    .rst_n  (rst_n),
    .load   (cap_load),
    .cmp_en (cap_cmp),
    .din    ($signed(bus.rd_data)),
    .result (pool_max)
  );

`ifdef MAXPOOL_RELU_EN
  assign pool_out = pool_max[BITWIDTH-1] ? '0 : pool_max;
`else
  assign pool_out = pool_max;
`endif

  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.rd_en   = rd_en_q;
  assign bus.rd_addr = rd_addr_q;
  assign bus.wr_en   = wr_en_q;
  assign bus.wr_addr = wr_addr_q;
  assign bus.wr_data = wr_en_q ? pool_out : '0;
endmodule

// File: tb/tb_maxpool_seq_ctrl.sv
// Bench for maxpool_seq_ctrl: random and ramp maps checked cycle by cycle against a window-max model,
// plus ignored starts, mid-window reset and a CHANNELS=1/IN_DIM=2 instance.
module tb_maxpool_seq_ctrl;
  localparam int BW  = 32;
  localparam int CH  = 2;
  localparam int ID  = 10;
  localparam int OD  = ID / 2;
  localparam int W   = CH * OD * OD;
  localparam int NRD = CH * ID * ID;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  maxpool_seq_ctrl_if #(.BITWIDTH(BW), .RD_AW(8), .WR_AW(6)) bus ();
  maxpool_seq_ctrl #(.BITWIDTH(BW), .CHANNELS(CH), .IN_DIM(ID)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  maxpool_seq_ctrl_if #(.BITWIDTH(BW), .RD_AW(2), .WR_AW(1)) bus2 ();
  maxpool_seq_ctrl #(.BITWIDTH(BW), .CHANNELS(1), .IN_DIM(2)) dut2 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus2)
  );

  int mem   [NRD];
  int map_a [NRD];
  int map_b [NRD];
  int mem2  [4];

  int vectors     = 0;
  int miscompares = 0;
  int cur_cyc     = 0;

  // Input buffers: one-cycle read latency, garbage on cycles without a read.
  always @(posedge clk) begin
    bus.rd_data  <= bus.rd_en  ? 32'(mem[bus.rd_addr])   : 32'($urandom);
    bus2.rd_data <= bus2.rd_en ? 32'(mem2[bus2.rd_addr]) : 32'($urandom);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cur_cyc, obs, exp);
    end
  endtask

  // Linear input address of the k-th read of window w.
  function automatic int rd_ref(input int w, input int k);
    int c  = w / (OD * OD);
    int i  = (w / OD) % OD;
    int j  = w % OD;
    return (c * ID + 2 * i + k % 2) * ID + 2 * j + k / 2;
  endfunction

  function automatic int pool_ref(input bit use_b, input int w);
    int best = 0;
    int v;
    for (int k = 0; k < 4; k++) begin
      v = use_b ? map_b[rd_ref(w, k)] : map_a[rd_ref(w, k)];
      if (k == 0 || v > best) best = v;
    end
`ifdef MAXPOOL_RELU_EN
    if (best < 0) best = 0;
`endif
    return best;
  endfunction

  // Expected outputs in cycle m of a pass (start sampled at edge 0).
  task automatic check_cycle(input int m, input bit use_b);
    bit act = (m >= 1) && (m <= 5 * W);
    int w   = (m - 1) / 5;
    int k   = (m - 1) % 5;
    chk("busy",  32'(bus.busy),  32'(act));
    chk("done",  32'(bus.done),  32'(m == 5 * W + 1));
    chk("rd_en", 32'(bus.rd_en), 32'(act && k != 4));
    chk("wr_en", 32'(bus.wr_en), 32'(act && k == 4));
    if (act && k != 4) chk("rd_addr", 32'(bus.rd_addr), 32'(rd_ref(w, k)));
    if (act && k == 4) begin
      chk("wr_addr", 32'(bus.wr_addr), 32'(w));
      chk("wr_data", bus.wr_data, 32'(pool_ref(use_b, w)));
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_busy"},    32'(bus.busy),    32'd0);
    chk({tag, "_done"},    32'(bus.done),    32'd0);
    chk({tag, "_rd_en"},   32'(bus.rd_en),   32'd0);
    chk({tag, "_rd_addr"}, 32'(bus.rd_addr), 32'd0);
    chk({tag, "_wr_en"},   32'(bus.wr_en),   32'd0);
    chk({tag, "_wr_addr"}, 32'(bus.wr_addr), 32'd0);
    chk({tag, "_wr_data"}, bus.wr_data,      32'd0);
  endtask

  initial begin
    int exp2;
    int nrd2;
    int nwr2;
    int ord2 [4];
    ord2[0] = 0; ord2[1] = 2; ord2[2] = 1; ord2[3] = 3;

    for (int a = 0; a < NRD; a++) begin
      map_a[a] = int'($urandom);
      map_b[a] = a;
    end
    // Window 0 signed mix, window 1 all -1, window 2 all tied.
    map_a[0] = -5; map_a[10] = -2; map_a[1] = -9; map_a[11] = -3;
    map_a[2] = -1; map_a[12] = -1; map_a[3] = -1; map_a[13] = -1;
    map_a[4] = 7;  map_a[14] = 7;  map_a[5] = 7;  map_a[15] = 7;
    mem = map_a;
    for (int a = 0; a < 4; a++) mem2[a] = int'($urandom);

    bus.start  = 1'b0;
    bus2.start = 1'b0;

    #2 rst_n = 1'b0;
    #1 chk_all_zero("rst");
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;

    // Pass 1 on the random map, ignored starts in cycles 3 and 251, pass 2 (ramp) from cycle 252.
    bus.start = 1'b1;
    @(posedge clk); #1;
    for (int n = 1; n <= 504; n++) begin
      bus.start = (n == 3) || (n == 251) || (n == 252);
      if (n == 252) mem = map_b;
      @(negedge clk);
      cur_cyc = n;
      if (n <= 252) check_cycle(n, 1'b0);
      else          check_cycle(n - 252, 1'b1);
      if (n == 5)   chk("sgn_win",  bus.wr_data, 32'hFFFF_FFFE);
`ifdef MAXPOOL_RELU_EN
      if (n == 10)  chk("neg1_win", bus.wr_data, 32'd0);
`else
      if (n == 10)  chk("neg1_win", bus.wr_data, 32'hFFFF_FFFF);
`endif
      if (n == 15)  chk("tie_win",  bus.wr_data, 32'd7);
      if (n == 26)  chk("win5_addr", 32'(bus.rd_addr), 32'd20);
      if (n == 253) chk("p2_rd_en", 32'(bus.rd_en), 32'd1);
      if (n == 257) chk("ramp_w0",  bus.wr_data, 32'd11);
      @(posedge clk); #1;
    end

    // Reset in cycle 7 (window 1 in flight): outputs clear at once, window 1 never written.
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    for (int n = 1; n <= 6; n++) begin
      @(negedge clk);
      cur_cyc = n;
      check_cycle(n, 1'b1);
      @(posedge clk); #1;
    end
    cur_cyc = 7;
    rst_n = 1'b0;
    #1 chk_all_zero("midrst");
    for (int n = 7; n <= 12; n++) begin
      if (n == 9) rst_n = 1'b1;
      @(negedge clk);
      cur_cyc = n;
      chk("post_rst_wr_en", 32'(bus.wr_en), 32'd0);
      chk("post_rst_rd_en", 32'(bus.rd_en), 32'd0);
      chk("post_rst_busy",  32'(bus.busy),  32'd0);
      @(posedge clk); #1;
    end

    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    for (int n = 1; n <= 252; n++) begin
      @(negedge clk);
      cur_cyc = n;
      check_cycle(n, 1'b1);
      @(posedge clk); #1;
    end

    // Smallest configuration: one channel, 2x2 input.
    exp2 = mem2[0];
    for (int a = 1; a < 4; a++) if (mem2[a] > exp2) exp2 = mem2[a];
`ifdef MAXPOOL_RELU_EN
    if (exp2 < 0) exp2 = 0;
`endif
    nrd2 = 0;
    nwr2 = 0;
    bus2.start = 1'b1;
    @(posedge clk); #1;
    bus2.start = 1'b0;
    for (int n = 1; n <= 8; n++) begin
      @(negedge clk);
      cur_cyc = n;
      if (bus2.rd_en) nrd2++;
      if (bus2.wr_en) nwr2++;
      chk("s_busy",  32'(bus2.busy),  32'(n >= 1 && n <= 5));
      chk("s_done",  32'(bus2.done),  32'(n == 6));
      chk("s_rd_en", 32'(bus2.rd_en), 32'(n >= 1 && n <= 4));
      chk("s_wr_en", 32'(bus2.wr_en), 32'(n == 5));
      if (n >= 1 && n <= 4) chk("s_rd_addr", 32'(bus2.rd_addr), 32'(ord2[n - 1]));
      if (n == 5) begin
        chk("s_wr_addr", 32'(bus2.wr_addr), 32'd0);
        chk("s_wr_data", bus2.wr_data, 32'(exp2));
      end
      @(posedge clk); #1;
    end
    chk("s_nreads",  32'(nrd2), 32'd4);
    chk("s_nwrites", 32'(nwr2), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/maxpool_seq_ctrl.md
# maxpool_seq_ctrl

Sequential 2×2/stride-2 max-pooling engine for the CNN feature-map path. It streams a CHANNELS×IN_DIM×IN_DIM feature map out of a single-port read buffer one word per cycle and reduces each 2×2 window with one comparator. It writes the CHANNELS×(IN_DIM/2)×(IN_DIM/2) pooled map into an output buffer. It replaces wide combinational pooling where the feature map lives in memory rather than in flops, and it is started by the layer sequencer through a start/done handshake.

## Interface
- BITWIDTH, 32, element width; elements are signed two's complement.
- CHANNELS, 2, number of feature-map channels.
- IN_DIM, 10, input rows and columns. Must be even and ≥2. OUT_DIM = IN_DIM/2 (localparam).
- Derived localparams: RD_AW = $clog2(CHANNELS*IN_DIM*IN_DIM), WR_AW = $clog2(CHANNELS*OUT_DIM*OUT_DIM).
- clk  in  1  sole clock; all logic is rising-edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  pulse that begins one full pass; sampled only in IDLE.
- busy  out  1  high while a pass is in progress.
- done  out  1  one-cycle pulse after the final write.
- rd_en  out  1  read strobe to the input buffer.
- rd_addr  out  RD_AW  linear address c*IN_DIM² + r*IN_DIM + col.
- rd_data  in  BITWIDTH  read data, valid exactly one cycle after rd_en.
- wr_en  out  1  write strobe to the output buffer.
- wr_addr  out  WR_AW  linear address c*OUT_DIM² + i*OUT_DIM + j.
- wr_data  out  BITWIDTH  pooled value.

## Operation
- States:
  - IDLE →(start)→ RD.
  - RD, 4 cycles with sub-counter k = 0..3 → WR.
  - WR, 1 cycle → RD for the next window, or → DONE after the last window.
  - DONE, 1 cycle → IDLE.
- Window order: channel outermost, then row i, then column j innermost.
- Read order within window (i,j): (2i,2j), (2i+1,2j), (2i,2j+1), (2i+1,2j+1).
- Accumulator:
  - The cycle after RD k=0 loads rd_data.
  - The cycles after k=1 and k=2 keep the signed max of accumulator and rd_data.
  - The WR cycle drives wr_data = signed max(accumulator, rd_data) combinationally from the 4th read.
- Ties keep the earlier element; results are bit-identical either way.
- The accumulator is re-loaded at each window; nothing carries across windows.
- start while busy or in DONE is ignored. rd_data is ignored outside capture cycles.
- rst_n low at any time, including mid-window:
  - immediately returns to IDLE and clears counters and accumulator;
  - drives all outputs to 0;
  - completes no partial write. The pass must be restarted.

## Timing
- Reset values: busy=0, done=0, rd_en=0, rd_addr=0, wr_en=0, wr_addr=0, wr_data=0.
- Cycle numbering: start sampled high at edge 0. Cycles 1..5·W are busy, where W = CHANNELS·OUT_DIM².
- Window w (0-based):
  - rd_en high in cycles 5w+1..5w+4;
  - wr_en high in cycle 5w+5, with wr_addr = w.
- Throughput is one window per 5 cycles. Default W = 50, so the pass takes 250 busy cycles.
- done=1 and busy=0 in cycle 5W+1. A start sampled in cycle 5W+2 (IDLE) is accepted.
- rd_en and wr_en are never high in the same cycle. Outputs are registered except wr_data.

## Configuration
- MAXPOOL_RELU_EN defined: wr_data = (result < 0) ? 0 : result. This fuses ReLU after pooling.
- MAXPOOL_RELU_EN undefined: wr_data = raw signed max. Timing is identical in both builds.

## Structure
- Package maxpool_pkg:
  - state enum typedef (IDLE, RD, WR, DONE);
  - window-offset constants for the read order;
  - a signed max2 function.
- Sub-module maxpool_cmp: registered signed compare/accumulate unit with load, compare and result ports, parameterised by BITWIDTH.
- The controller holds the FSM, the c/i/j/k counters and the address generation.

## Test plan
- Reset then one pass on a ramp map (value = address) → 50 writes; wr_data at wr_addr w = address of (2i+1, 2j+1); done in cycle 251.
- Per-window read order: watch rd_addr for window w=0 → 0, 10, 1, 11, then wr_addr=0 in cycle 5. Window w=5 starts at rd_addr 20.
- Signed data: window {-5, -2, -9, -3} → wr_data = -2. All -1 → -1 without MAXPOOL_RELU_EN, and 0 with it.
- start pulsed in cycles 3 and 251 → ignored. A start in cycle 252 → a second pass whose first rd_en is in cycle 253.
- rst_n asserted in cycle 7 (mid window 1) → all outputs 0 immediately and no write for window 1. A new start gives a full 250-cycle pass.
- Parameter sweep CHANNELS=1, IN_DIM=2 → 4 reads, 1 write at addr 0, done in cycle 6.
